contador_mod_n: RTL and testbench
=================================

CONTADOR_MOD_N -- requirements
Module: contador_mod_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter register width in bits.
REQ-002 The block SHALL have parameter MODULO, default 14: count range 0..MODULO-1; legal values 2..2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port d, input, WIDTH bits: load value.
REQ-009 The block SHALL have port q, output, WIDTH bits: current count.
REQ-010 The block SHALL have port tc, output, 1 bit: terminal count, for cascading.
REQ-011 The block SHALL have port wrap, output, 1 bit: registered wrap-event pulse.
REQ-012 The block SHALL have port load_err, output, 1 bit: registered out-of-range-load pulse.

Function
REQ-013 Update priority SHALL be: reset, then load, then en, then hold.
REQ-014 With en=1, up=1 and q<MODULO-1, q SHALL become q+1 at the next edge.
REQ-015 With en=1, up=1 and q=MODULO-1, q SHALL become 0 at the next edge (wrap-around).
REQ-016 With en=1, up=0 and q>0, q SHALL become q-1 at the next edge.
REQ-017 With en=1, up=0 and q=0, q SHALL become MODULO-1 at the next edge (wrap-around).
REQ-018 With en=0 and load=0, q SHALL hold its value.
REQ-019 tc SHALL be combinational and equal en AND ((up AND q=MODULO-1) OR (NOT up AND q=0)).
REQ-020 tc SHALL NOT depend on load; when load=1, tc still reflects en, up and q.
REQ-021 wrap SHALL be 1 for exactly one cycle, the cycle after any edge on which a wrap transition occurred; otherwise 0.
REQ-022 On load=1 with d<=MODULO-1, q SHALL become d at the next edge and load_err SHALL be 0 the following cycle.
REQ-023 On load=1 with d>=MODULO, q SHALL become MODULO-1 (clamp) and load_err SHALL be 1 for exactly one cycle.
REQ-024 A load SHALL NOT raise wrap, even when en=1 and q is at its terminal value.
REQ-025 A direction change SHALL take effect on the same edge at which up is sampled; no pipeline latency.
REQ-026 Illegal MODULO (<2 or >2^WIDTH) SHALL stop elaboration via a generate-time error.

Reset
REQ-027 On a rising clk edge with rst_n=0, the block SHALL set q=0, wrap=0 and load_err=0, overriding load and en.
REQ-028 A mid-count reset SHALL clear the state in one edge; counting SHALL resume from 0 on the first edge with rst_n=1.
REQ-029 tc SHALL follow its REQ-019 equation from q=0 during reset; reset SHALL NOT gate tc.

Configuration
REQ-030 The macro CONTADOR_SAT_EN, when defined, SHALL add input port sat (1 bit).
REQ-031 With CONTADOR_SAT_EN defined and sat=1, the counter SHALL hold at MODULO-1 counting up and hold at 0 counting down; wrap stays 0 and tc still asserts.
REQ-032 With CONTADOR_SAT_EN defined and sat=0, and without CONTADOR_SAT_EN, the block SHALL behave exactly per REQ-014 to REQ-017 and SHALL have no sat port.

Verification
REQ-033 Bench SHALL check: defaults (4/14), reset 1 cycle, then en=1, up=1 for 30 cycles -> q sequence 0..13,0..13,0,1; wrap=1 the cycle after each 13->0; tc=1 whenever q=13.
REQ-034 Bench SHALL check: up=0 from q=0 -> q=13,12,...; wrap pulse after 0->13; tc=1 whenever q=0.
REQ-035 Bench SHALL check: load=1, d=9 -> q=9, load_err=0; load=1, d=15 -> q=13, load_err=1 for one cycle; load with en=1 at q=13 -> no wrap.
REQ-036 Bench SHALL check: rst_n=0 asserted at q=7 with load=1 and en=1 -> q=0, wrap=0, load_err=0 next edge; counting from 0 after release.
REQ-037 Bench SHALL check: WIDTH=8, MODULO=200, en toggled every other cycle -> q advances only on en=1 cycles and wraps 199->0.
REQ-038 Bench SHALL check: CONTADOR_SAT_EN defined, sat=1, up=1 from 12 -> q=13,13,13, wrap=0, tc=1; with sat=0 -> 13->0.

Source files
------------

// File: rtl/contador_mod_n.sv
// Modulo-N up/down counter with synchronous load (clamped), terminal count and wrap/load-error pulses.
// Optional saturation mode enabled by defining CONTADOR_SAT_EN (adds the sat input).
module contador_mod_n #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
`ifdef CONTADOR_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
            $error("contador_mod_n: MODULO must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    // One extra bit so MODULO == 2**WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             sat_i;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             load_err_nxt;
    logic             at_max;
    logic             at_min;

`ifdef CONTADOR_SAT_EN
    assign sat_i = sat;
`else
    assign sat_i = 1'b0;
`endif

    assign at_max = (q == Q_MAX);
    assign at_min = (q == '0);
    assign tc     = en & ((up & at_max) | (~up & at_min));

    always_comb begin
        q_nxt        = q;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (load) begin
            if ({1'b0, d} >= MOD_EXT) begin
                q_nxt        = Q_MAX;
                load_err_nxt = 1'b1;
            end else begin
                q_nxt = d;
            end
        end else if (en) begin
            if (tc) begin
                // At the terminal value: either hold (saturating) or wrap to the other end.
                if (!sat_i) begin
                    q_nxt    = up ? '0 : Q_MAX;
                    wrap_nxt = 1'b1;
                end
            end else begin
                q_nxt = up ? (q + ONE) : (q - ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_contador_mod_n.sv
// Bench for contador_mod_n: default 4/14 instance plus an 8/200 instance, scoreboard-checked.
// Saturation scenarios run only when CONTADOR_SAT_EN is defined.
module tb_contador_mod_n;

    typedef struct {
        string tag;
        int    q;
        bit    wrap;
        bit    lerr;
    } exp_t;

`ifdef CONTADOR_SAT_EN
    localparam bit SAT_BUILT = 1'b1;
`else
    localparam bit SAT_BUILT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, up, load, sat_v;
    logic [3:0] d, q;
    logic       tc, wrap, load_err;

    logic       rst_nb, en_b, up_b, load_b, sat_b;
    logic [7:0] d_b, q_b;
    logic       tc_b, wrap_b, lerr_b;

    int   n_checks = 0;
    int   n_err    = 0;
    int   mq, mqb;
    exp_t sb_q[$];
    exp_t sb_b[$];

    contador_mod_n dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
`ifdef CONTADOR_SAT_EN
        .sat(sat_v),
`endif
        .d(d), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    contador_mod_n #(.WIDTH(8), .MODULO(200)) dut_b (
        .clk(clk), .rst_n(rst_nb), .en(en_b), .up(up_b), .load(load_b),
`ifdef CONTADOR_SAT_EN
        .sat(sat_b),
`endif
        .d(d_b), .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(lerr_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle on the 4/14 instance: drive, check tc, push expectation, clock, pop and compare.
    task automatic step_a(input bit r, input bit e, input bit u, input bit l, input int dv,
                          input bit s, input string tag);
        exp_t x;
        int   nq;
        bit   nw, nl, sat_eff;
        rst_n = r; en = e; up = u; load = l; d = dv[3:0]; sat_v = s;
        #1;
        check({tag, ".tc"}, 32'(tc), 32'(e && ((u && mq == 13) || (!u && mq == 0))));
        sat_eff = s && SAT_BUILT;
        nq = mq; nw = 1'b0; nl = 1'b0;
        if (!r) nq = 0;
        else if (l) begin
            if (dv >= 14) begin nq = 13; nl = 1'b1; end
            else nq = dv;
        end else if (e) begin
            if (u) begin
                if (mq == 13) begin
                    if (!sat_eff) begin nq = 0; nw = 1'b1; end
                end else nq = mq + 1;
            end else begin
                if (mq == 0) begin
                    if (!sat_eff) begin nq = 13; nw = 1'b1; end
                end else nq = mq - 1;
            end
        end
        mq = nq;
        x.tag = tag; x.q = nq; x.wrap = nw; x.lerr = nl;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check({x.tag, ".q"},    32'(q),        32'(x.q));
        check({x.tag, ".wrap"}, 32'(wrap),     32'(x.wrap));
        check({x.tag, ".lerr"}, 32'(load_err), 32'(x.lerr));
    endtask

    task automatic step_b(input bit r, input bit e, input string tag);
        exp_t x;
        int   nq;
        bit   nw;
        rst_nb = r; en_b = e;
        #1;
        check({tag, ".tc"}, 32'(tc_b), 32'(e && mqb == 199));
        nq = mqb; nw = 1'b0;
        if (!r) nq = 0;
        else if (e) begin
            if (mqb == 199) begin nq = 0; nw = 1'b1; end
            else nq = mqb + 1;
        end
        mqb = nq;
        x.tag = tag; x.q = nq; x.wrap = nw; x.lerr = 1'b0;
        sb_b.push_back(x);
        @(posedge clk);
        #1;
        x = sb_b.pop_front();
        check({x.tag, ".q"},    32'(q_b),    32'(x.q));
        check({x.tag, ".wrap"}, 32'(wrap_b), 32'(x.wrap));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wraps_seen;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0; sat_v = 1'b0;
        rst_nb = 1'b0; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; d_b = '0; sat_b = 1'b0;
        mq = 0; mqb = 0;
        @(posedge clk);
        #1;
        check("rst.q",    32'(q),        32'd0);
        check("rst.wrap", 32'(wrap),     32'd0);
        check("rst.lerr", 32'(load_err), 32'd0);
        check("rst.q_b",  32'(q_b),      32'd0);

        // Count up through two full periods
        for (int i = 0; i < 30; i++) begin
            step_a(1, 1, 1, 0, 0, 0, "up");
            check("up.seq", 32'(q), 32'((i + 1) % 14));
        end
        for (int i = 0; i < 3; i++) step_a(1, 0, 1, 0, 0, 0, "hold");

        // Count down from 0
        step_a(0, 0, 1, 0, 0, 0, "rst2");
        for (int i = 0; i < 20; i++) begin
            step_a(1, 1, 0, 0, 0, 0, "dn");
            check("dn.seq", 32'(q), 32'((14 - ((i + 1) % 14)) % 14));
        end

        // Loads: in range, clamped, and load overriding a terminal count
        step_a(1, 0, 1, 1, 9, 0, "ld9");
        check("ld9.val", 32'(q), 32'd9);
        step_a(1, 0, 1, 1, 15, 0, "ld15");
        check("ld15.val", 32'(q), 32'd13);
        step_a(1, 0, 1, 0, 0, 0, "ld_after");
        step_a(1, 1, 1, 1, 5, 0, "ld_tc");
        check("ld_tc.val", 32'(q), 32'd5);

        // Mid-count reset beats load and en
        step_a(1, 0, 1, 1, 7, 0, "ld7");
        step_a(0, 1, 1, 1, 15, 0, "rst_mid");
        check("rst_mid.val", 32'(q), 32'd0);
        for (int i = 0; i < 3; i++) step_a(1, 1, 1, 0, 0, 0, "resume");
        check("resume.val", 32'(q), 32'd3);

        // Wide instance with en toggling every other cycle
        wraps_seen = 0;
        step_b(1, 1'b0, "b_start");
        for (int i = 0; i < 420; i++) begin
            step_b(1, (i % 2) == 0, "b_cnt");
            if (wrap_b) wraps_seen++;
        end
        check("b.wraps", 32'(wraps_seen), 32'd1);
        check("b.final", 32'(q_b), 32'd10);

`ifdef CONTADOR_SAT_EN
        step_a(1, 0, 1, 1, 12, 0, "sat_ld");
        for (int i = 0; i < 4; i++) begin
            step_a(1, 1, 1, 0, 0, 1, "sat_up");
            check("sat_up.val", 32'(q), 32'd13);
        end
        step_a(1, 1, 1, 0, 0, 0, "nosat_up");
        check("nosat_up.val", 32'(q), 32'd0);
        for (int i = 0; i < 3; i++) step_a(1, 1, 0, 0, 0, 1, "sat_dn");
        check("sat_dn.val", 32'(q), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
